// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding and op width.
package md_unit_pkg;

  localparam int unsigned MdOpW = 3;

  localparam logic [MdOpW-1:0] MD_OP_MULT  = 3'd0;
  localparam logic [MdOpW-1:0] MD_OP_MULTU = 3'd1;
  localparam logic [MdOpW-1:0] MD_OP_DIV   = 3'd2;
  localparam logic [MdOpW-1:0] MD_OP_DIVU  = 3'd3;
  localparam logic [MdOpW-1:0] MD_OP_MTHI  = 3'd4;
  localparam logic [MdOpW-1:0] MD_OP_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } md_state_e;

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the {hi, lo} pair for one op,
// including signed handling and the divide-by-zero / signed-overflow cases.
module md_calc
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [MdOpW-1:0] op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH - 1){1'b0}}};

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   div_b;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;

  assign prod_s = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
  assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // Signed divide runs on magnitudes; the most-negative dividend maps to 2^(WIDTH-1) unsigned.
  assign a_neg = (op_i == MD_OP_DIV) && a_i[WIDTH-1];
  assign b_neg = (op_i == MD_OP_DIV) && b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;
  assign div_b = (b_i == '0) ? WIDTH'(1) : b_mag;
  assign q_mag = a_mag / div_b;
  assign r_mag = a_mag % div_b;

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    case (op_i)
      MD_OP_MULT:  {hi_o, lo_o} = prod_s;
      MD_OP_MULTU: {hi_o, lo_o} = prod_u;
      MD_OP_DIV, MD_OP_DIVU: begin
        if (b_i == '0) begin
          hi_o = a_i;
          lo_o = '1;
        end else if ((op_i == MD_OP_DIV) && (a_i == MostNeg) && (b_i == '1)) begin
          hi_o = '0;
          lo_o = MostNeg;
        end else begin
          lo_o = (a_neg ^ b_neg) ? -q_mag : q_mag;
          hi_o = a_neg ? -r_mag : r_mag;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; results are computed on
// acceptance and committed after a fixed latency, with flush-cancel via clear_i.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [MdOpW-1:0] op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             clear_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;
  logic             accept;

  md_calc #(
    .WIDTH(WIDTH)
  ) u_md_calc (
    .op_i(op_i),
    .a_i (a_i),
    .b_i (b_i),
    .hi_o(calc_hi),
    .lo_o(calc_lo)
  );

  assign accept = start_i && (state_q == StIdle) && !clear_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op_i)
            MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
              pend_hi_d = calc_hi;
              pend_lo_d = calc_lo;
              cnt_d     = op_i[1] ? DivLoad : MultLoad;
              state_d   = StRun;
            end
            MD_OP_MTHI: hi_d = a_i;
            MD_OP_MTLO: lo_d = a_i;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (clear_i) begin
          state_d   = StIdle;
          cnt_d     = '0;
          pend_hi_d = '0;
          pend_lo_d = '0;
        end else if (cnt_q == '0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: scoreboard of expected {HI,LO} pushed at issue,
// popped and compared when busy falls.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned NM = 5;
  localparam int unsigned ND = 10;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         clear;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks;
  int failures;
  logic [2*W-1:0] sb_q[$];
  logic [W-1:0]   cur_hi;
  logic [W-1:0]   cur_lo;

  md_unit #(
    .WIDTH      (W),
    .MULT_CYCLES(NM),
    .DIV_CYCLES (ND)
  ) dut (
    .clk_i  (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .clear_i(clear),
    .busy_o (busy),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [2:0] mop, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic signed [63:0] sx, sy;
    int                 ix, iy;
    logic [63:0]        r;
    sx = $signed(x);
    sy = $signed(y);
    ix = x;
    iy = y;
    r  = '0;
    case (mop)
      3'd0: r = sx * sy;
      3'd1: r = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(ix % iy), 32'(ix / iy)};
      end
      3'd3: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one op for a single edge; arithmetic ops push their expected result.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2*W-1:0] exp_v, input bit push);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (push) sb_q.push_back(exp_v);
    step();
    start = 1'b0;
  endtask

  // Count busy cycles until busy falls, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
    step();
    rst_n  = 1'b1;
    cur_hi = '0;
    cur_lo = '0;
    step();
  endtask

  task automatic test_mult();
    int n;
    logic [2*W-1:0] e;
    issue(MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 1'b1);
    wait_idle(n);
    e = sb_q.pop_front();
    checks++;
    if (n !== NM) begin
      failures++;
      $display("FAIL mult_busy: cycles=%0d required %0d", n, NM);
    end
    checks++;
    if ({hi, lo} !== e) begin
      failures++;
      $display("FAIL mult: got %h required %h", {hi, lo}, e);
    end
    issue(MD_OP_MULTU, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA}, 1'b1);
    wait_idle(n);
    e = sb_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin
      failures++;
      $display("FAIL multu: got %h required %h", {hi, lo}, e);
    end
    {cur_hi, cur_lo} = e;
  endtask

  task automatic test_div();
    int n;
    logic [2*W-1:0] e;
    issue(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    wait_idle(n);
    e = sb_q.pop_front();
    checks++;
    if (n !== ND) begin
      failures++;
      $display("FAIL div_busy: cycles=%0d required %0d", n, ND);
    end
    checks++;
    if ({hi, lo} !== e) begin
      failures++;
      $display("FAIL div: got %h required %h", {hi, lo}, e);
    end
    issue(MD_OP_DIVU, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF}, 1'b1);
    wait_idle(n);
    e = sb_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin
      failures++;
      $display("FAIL divu_zero: got %h required %h", {hi, lo}, e);
    end
    issue(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b1);
    wait_idle(n);
    e = sb_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin
      failures++;
      $display("FAIL div_ovf: got %h required %h", {hi, lo}, e);
    end
    {cur_hi, cur_lo} = e;
  endtask

  task automatic test_mthi();
    int n;
    logic [2*W-1:0] e;
    issue(MD_OP_MTHI, 32'h1234, 32'd0, '0, 1'b0);
    cur_hi = 32'h1234;
    checks++;
    if (hi !== cur_hi || lo !== cur_lo || busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b required %h %h 0", hi, lo, busy, cur_hi, cur_lo);
    end
    issue(MD_OP_MTLO, 32'h5678, 32'd0, '0, 1'b0);
    cur_lo = 32'h5678;
    checks++;
    if (lo !== cur_lo || hi !== cur_hi) begin
      failures++;
      $display("FAIL mtlo: hi=%h lo=%h required %h %h", hi, lo, cur_hi, cur_lo);
    end
    // mthi while busy must be dropped
    issue(MD_OP_MULTU, 32'd100, 32'd200, model(MD_OP_MULTU, 32'd100, 32'd200), 1'b1);
    issue(MD_OP_MTHI, 32'hDEAD, 32'd0, '0, 1'b0);
    checks++;
    if (hi !== cur_hi) begin
      failures++;
      $display("FAIL mthi_busy: hi=%h required %h", hi, cur_hi);
    end
    wait_idle(n);
    e = sb_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin
      failures++;
      $display("FAIL mthi_busy_commit: got %h required %h", {hi, lo}, e);
    end
    {cur_hi, cur_lo} = e;
  endtask

  task automatic test_clear();
    issue(MD_OP_DIV, 32'd100, 32'd7, '0, 1'b0);
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== cur_hi || lo !== cur_lo) begin
      failures++;
      $display("FAIL clear_run: busy=%b hi=%h lo=%h required 0 %h %h", busy, hi, lo, cur_hi,
               cur_lo);
    end
    repeat (12) step();
    checks++;
    if (hi !== cur_hi || lo !== cur_lo) begin
      failures++;
      $display("FAIL clear_late: hi=%h lo=%h required %h %h", hi, lo, cur_hi, cur_lo);
    end
  endtask

  task automatic test_start_clear();
    clear = 1'b1;
    issue(MD_OP_MTLO, 32'hBEEF, 32'd0, '0, 1'b0);
    checks++;
    if (lo !== cur_lo || busy !== 1'b0) begin
      failures++;
      $display("FAIL start_clear_mtlo: lo=%h busy=%b required %h 0", lo, busy, cur_lo);
    end
    issue(MD_OP_DIV, 32'd9, 32'd2, '0, 1'b0);
    clear = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_clear_div: busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [2*W-1:0] e;
    logic [2:0]     o;
    logic [W-1:0]   x, y;
    for (int i = 0; i < 8; i++) begin
      o = 3'(i % 4);
      x = $urandom();
      y = (i == 6) ? 32'd0 : $urandom();
      if (i == 3) y = y >> 20;
      issue(o, x, y, model(o, x, y), 1'b1);
      wait_idle(n);
      e = sb_q.pop_front();
      checks++;
      if (n !== ((o >= 3'd2) ? ND : NM) || {hi, lo} !== e) begin
        failures++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h: cycles=%0d got %h required %h", i, o, x, y, n,
                 {hi, lo}, e);
      end
      {cur_hi, cur_lo} = e;
    end
  endtask

  task automatic test_async_reset();
    issue(MD_OP_MULT, 32'd3, 32'd5, '0, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL async_reset: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
    step();
    rst_n = 1'b1;
    cur_hi = '0;
    cur_lo = '0;
    repeat (8) step();
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL after_reset: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    op       = '0;
    a        = '0;
    b        = '0;
    clear    = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_mthi();
    test_clear();
    test_start_clear();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
